// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port integer register file: default
// geometry and ABI register names.
package regfile_mp_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // ABI names for the low integer registers.
    typedef enum logic [4:0] {
        REG_ZERO = 5'd0,
        REG_RA   = 5'd1,
        REG_SP   = 5'd2,
        REG_GP   = 5'd3,
        REG_TP   = 5'd4,
        REG_T0   = 5'd5,
        REG_T1   = 5'd6,
        REG_T2   = 5'd7,
        REG_S0   = 5'd8,
        REG_S1   = 5'd9,
        REG_A0   = 5'd10,
        REG_A1   = 5'd11
    } abi_reg_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. Set (producer issue)
// beats clear (writeback) on the same register; register 0 is never busy.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 1,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sb_set_en,
    input  logic [AW-1:0]      sb_set_addr,
    input  logic [NWR-1:0]     wr_en,
    input  logic [NWR*AW-1:0]  wr_addr,
    input  logic [NWR-1:0]     sb_clr,
    output logic [NREG-1:0]    busy_d
);

    logic [NREG-1:0] busy_q;

    // Next scoreboard state: clears first, then the set overrides them.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && sb_clr[k]) begin
                busy_d[wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_en) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy bit storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with write-first bypass,
// hardwired zero register and a pending-write scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    input  logic [NRD-1:0]       rd_en,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic [NWR-1:0]       sb_clr
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_d;
    logic [XLEN-1:0] rd_val_d [NRD];
    logic [NRD-1:0]  rd_bsy_d;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_clr      (sb_clr),
        .busy_d      (busy_d)
    );

    // Per read port: storage value overridden by matching writes, higher
    // write ports later in the chain so they take priority.
    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] chain [NWR+1];

        assign ra       = rd_addr[j*AW +: AW];
        assign chain[0] = regs_q[ra];

        for (genvar k = 0; k < NWR; k++) begin : g_byp
            assign chain[k+1] = (wr_en[k] && (wr_addr[k*AW +: AW] == ra) && (ra != '0))
                                ? wr_data[k*XLEN +: XLEN] : chain[k];
        end

        assign rd_val_d[j] = chain[NWR];
        assign rd_bsy_d[j] = busy_d[ra];
    end

    // Register storage; later loop iterations win so the highest port index
    // takes a same-address conflict. Register 0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
                    regs_q[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Registered read outputs; a disabled port holds its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int j = 0; j < NRD; j++) begin
                if (rd_en[j]) begin
                    rd_data[j*XLEN +: XLEN] <= rd_val_d[j];
                    rd_busy[j]              <= rd_bsy_d[j];
                end
            end
        end
    end

endmodule
